adma_as_atx_sched: RTL and testbench

Weighted AXI-transaction scheduler for the DMA AXI-stream side. It collects AR/AW descriptor-beats from DMA_CHN_NUM channels and picks one per cycle using an internal credit-based weighted round robin, or plain round robin when selected. It caps outstanding transactions per channel, using a completion-return port, and drives a registered output stage toward the AXI master. It sits between the per-channel transaction generators and the AXI AR/AW issue logic.

---
 rtl/adma_as_pkg.sv | 23 ++
 rtl/adma_as_atx_wrr_pick.sv | 56 +++++
 rtl/adma_as_atx_sched.sv | 170 +++++++++++++++++
 tb/tb_adma_as_atx_sched.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adma_as_pkg.sv
// Shared types and helpers for the DMA AXI-stream transaction scheduler.
package adma_as_pkg;

  typedef enum logic {
    ARB_RR  = 1'b0,
    ARB_WRR = 1'b1
  } arb_mode_e;

  localparam int DEF_CHN_NUM = 4;
  localparam int DEF_ARB_W   = 3;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_ID_W    = 5;
  localparam int DEF_LEN_W   = 8;
  localparam int DEF_OST_MAX = 4;
  localparam int AXI_BURST_W = 2;

  // A zero weight in WRR still gets one grant per round so no channel starves.
  function automatic int unsigned load_weight(input int unsigned rate, input arb_mode_e mode);
    if (mode == ARB_RR) return 1;
    return (rate == 0) ? 1 : rate;
  endfunction

endpackage

// File: rtl/adma_as_atx_wrr_pick.sv
// Combinational credit-based WRR/RR pick: no state, zero latency, no backpressure
// of its own (the caller decides whether the pick is actually taken).
module adma_as_atx_wrr_pick
  import adma_as_pkg::*;
#(
  parameter int CHN_NUM = DEF_CHN_NUM,
  parameter int ARB_W   = DEF_ARB_W,
  parameter int CHN_W   = $clog2(CHN_NUM)
) (
  input  logic [CHN_NUM-1:0]       eligible,
  input  logic [CHN_W-1:0]         cur_chn,
  input  logic [ARB_W-1:0]         credit,
  input  logic [CHN_NUM*ARB_W-1:0] rate,
  input  logic                     arb_mode,
  output logic [CHN_W-1:0]         sel,
  output logic                     any_eligible,
  output logic [ARB_W-1:0]         credit_nxt
);

  logic             stay;
  logic             found;
  logic [CHN_W-1:0] idx;
  logic [CHN_W-1:0] scan_sel;
  logic [ARB_W-1:0] rate_sel;
  logic [ARB_W-1:0] weight;

  assign any_eligible = |eligible;
  assign stay         = (credit != '0) && eligible[cur_chn];

  // Scan starts after cur_chn so the current channel is considered last.
  always_comb begin
    found    = 1'b0;
    idx      = cur_chn;
    scan_sel = cur_chn;
    for (int k = 1; k <= CHN_NUM; k++) begin
      idx = CHN_W'((int'(cur_chn) + k) % CHN_NUM);
      if (!found && eligible[idx]) begin
        found    = 1'b1;
        scan_sel = idx;
      end
    end
  end

  assign sel = stay ? cur_chn : scan_sel;

  always_comb begin
    rate_sel = '0;
    for (int i = 0; i < CHN_NUM; i++) begin
      if (sel == CHN_W'(i)) rate_sel = rate[i*ARB_W +: ARB_W];
    end
  end

  assign weight     = ARB_W'(load_weight(32'(rate_sel), arb_mode_e'(arb_mode)));
  assign credit_nxt = stay ? (credit - ARB_W'(1)) : (weight - ARB_W'(1));

endmodule

// File: rtl/adma_as_atx_sched.sv
// Weighted AR/AW transaction scheduler with per-channel outstanding caps.
// 1-cycle bwd->fwd latency, full throughput; stalls accept while fwd output is held.
module adma_as_atx_sched
  import adma_as_pkg::*;
#(
  parameter int DMA_CHN_NUM   = DEF_CHN_NUM,
  parameter int DMA_CHN_ARB_W = DEF_ARB_W,
  parameter int SRC_ADDR_W    = DEF_ADDR_W,
  parameter int DST_ADDR_W    = DEF_ADDR_W,
  parameter int MST_ID_W      = DEF_ID_W,
  parameter int ATX_LEN_W     = DEF_LEN_W,
  parameter int OST_MAX       = DEF_OST_MAX,
  parameter int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM),
  parameter int OST_W         = $clog2(OST_MAX + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [MST_ID_W-1:0]                    bwd_arid    [0:DMA_CHN_NUM-1],
  input  logic [SRC_ADDR_W-1:0]                  bwd_araddr  [0:DMA_CHN_NUM-1],
  input  logic [ATX_LEN_W-1:0]                   bwd_arlen   [0:DMA_CHN_NUM-1],
  input  logic [AXI_BURST_W-1:0]                 bwd_arburst [0:DMA_CHN_NUM-1],
  input  logic [MST_ID_W-1:0]                    bwd_awid    [0:DMA_CHN_NUM-1],
  input  logic [DST_ADDR_W-1:0]                  bwd_awaddr  [0:DMA_CHN_NUM-1],
  input  logic [ATX_LEN_W-1:0]                   bwd_awlen   [0:DMA_CHN_NUM-1],
  input  logic [AXI_BURST_W-1:0]                 bwd_awburst [0:DMA_CHN_NUM-1],
  input  logic [DMA_CHN_NUM-1:0]                 bwd_atx_vld,
  output logic [DMA_CHN_NUM-1:0]                 bwd_atx_rdy,
  input  logic [DMA_CHN_NUM*DMA_CHN_ARB_W-1:0]   chn_arb_rate,
  input  logic                                   arb_mode,
  input  logic                                   atx_done_vld,
  input  logic [DMA_CHN_NUM_W-1:0]               atx_done_chn_id,
  output logic [DMA_CHN_NUM_W-1:0]               fwd_atx_chn_id,
  output logic [MST_ID_W-1:0]                    fwd_arid,
  output logic [SRC_ADDR_W-1:0]                  fwd_araddr,
  output logic [ATX_LEN_W-1:0]                   fwd_arlen,
  output logic [AXI_BURST_W-1:0]                 fwd_arburst,
  output logic [MST_ID_W-1:0]                    fwd_awid,
  output logic [DST_ADDR_W-1:0]                  fwd_awaddr,
  output logic [ATX_LEN_W-1:0]                   fwd_awlen,
  output logic [AXI_BURST_W-1:0]                 fwd_awburst,
  output logic                                   fwd_atx_vld,
  input  logic                                   fwd_atx_rdy,
  output logic [DMA_CHN_NUM*OST_W-1:0]           chn_ost_cnt
);

  logic [DMA_CHN_NUM_W-1:0] cur_chn;
  logic [DMA_CHN_NUM_W-1:0] sel;
  logic [DMA_CHN_ARB_W-1:0] credit;
  logic [DMA_CHN_ARB_W-1:0] credit_nxt;
  logic [OST_W-1:0]         ost_cnt [DMA_CHN_NUM];
  logic [DMA_CHN_NUM-1:0]   eligible;
  logic [DMA_CHN_NUM-1:0]   ost_dec;
  logic                     any_eligible;
  logic                     load_en;
  logic                     accept;

  logic [MST_ID_W-1:0]      sel_arid,    sel_awid;
  logic [SRC_ADDR_W-1:0]    sel_araddr;
  logic [DST_ADDR_W-1:0]    sel_awaddr;
  logic [ATX_LEN_W-1:0]     sel_arlen,   sel_awlen;
  logic [AXI_BURST_W-1:0]   sel_arburst, sel_awburst;

  always_comb begin
    eligible = '0;
    ost_dec  = '0;
    for (int i = 0; i < DMA_CHN_NUM; i++) begin
      eligible[i] = bwd_atx_vld[i] && (ost_cnt[i] < OST_W'(OST_MAX));
      ost_dec[i]  = atx_done_vld && (atx_done_chn_id == DMA_CHN_NUM_W'(i)) && (ost_cnt[i] != '0);
    end
  end

  adma_as_atx_wrr_pick #(
    .CHN_NUM (DMA_CHN_NUM),
    .ARB_W   (DMA_CHN_ARB_W),
    .CHN_W   (DMA_CHN_NUM_W)
  ) u_pick (
    .eligible     (eligible),
    .cur_chn      (cur_chn),
    .credit       (credit),
    .rate         (chn_arb_rate),
    .arb_mode     (arb_mode),
    .sel          (sel),
    .any_eligible (any_eligible),
    .credit_nxt   (credit_nxt)
  );

  assign load_en = ~fwd_atx_vld | fwd_atx_rdy;
  assign accept  = load_en & any_eligible;

  always_comb begin
    bwd_atx_rdy = '0;
    sel_arid    = '0;
    sel_araddr  = '0;
    sel_arlen   = '0;
    sel_arburst = '0;
    sel_awid    = '0;
    sel_awaddr  = '0;
    sel_awlen   = '0;
    sel_awburst = '0;
    for (int i = 0; i < DMA_CHN_NUM; i++) begin
      if (sel == DMA_CHN_NUM_W'(i)) begin
        bwd_atx_rdy[i] = accept;
        sel_arid       = bwd_arid[i];
        sel_araddr     = bwd_araddr[i];
        sel_arlen      = bwd_arlen[i];
        sel_arburst    = bwd_arburst[i];
        sel_awid       = bwd_awid[i];
        sel_awaddr     = bwd_awaddr[i];
        sel_awlen      = bwd_awlen[i];
        sel_awburst    = bwd_awburst[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_chn <= '0;
      credit  <= '0;
    end else if (accept) begin
      cur_chn <= sel;
      credit  <= credit_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_atx_vld    <= 1'b0;
      fwd_atx_chn_id <= '0;
      fwd_arid       <= '0;
      fwd_araddr     <= '0;
      fwd_arlen      <= '0;
      fwd_arburst    <= '0;
      fwd_awid       <= '0;
      fwd_awaddr     <= '0;
      fwd_awlen      <= '0;
      fwd_awburst    <= '0;
    end else if (accept) begin
      fwd_atx_vld    <= 1'b1;
      fwd_atx_chn_id <= sel;
      fwd_arid       <= sel_arid;
      fwd_araddr     <= sel_araddr;
      fwd_arlen      <= sel_arlen;
      fwd_arburst    <= sel_arburst;
      fwd_awid       <= sel_awid;
      fwd_awaddr     <= sel_awaddr;
      fwd_awlen      <= sel_awlen;
      fwd_awburst    <= sel_awburst;
    end else if (fwd_atx_rdy) begin
      fwd_atx_vld    <= 1'b0;
    end
  end

  // A done for an idle channel is dropped; accept plus done cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMA_CHN_NUM; i++) ost_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < DMA_CHN_NUM; i++) begin
        if (bwd_atx_rdy[i] && !ost_dec[i])      ost_cnt[i] <= ost_cnt[i] + OST_W'(1);
        else if (ost_dec[i] && !bwd_atx_rdy[i]) ost_cnt[i] <= ost_cnt[i] - OST_W'(1);
      end
    end
  end

  always_comb begin
    chn_ost_cnt = '0;
    for (int i = 0; i < DMA_CHN_NUM; i++) chn_ost_cnt[i*OST_W +: OST_W] = ost_cnt[i];
  end

endmodule

// File: tb/tb_adma_as_atx_sched.sv
// Randomized and directed bench for adma_as_atx_sched with a reference model and scoreboard.
module tb_adma_as_atx_sched;
  import adma_as_pkg::*;

  localparam int N    = 4;
  localparam int AW   = 3;
  localparam int IDW  = 5;
  localparam int LW   = 8;
  localparam int OMAX = 3;
  localparam int CW   = 2;
  localparam int OW   = 2;
  localparam int PW   = CW + 2 * (IDW + 32 + LW + 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [IDW-1:0]  bwd_arid    [0:N-1];
  logic [31:0]     bwd_araddr  [0:N-1];
  logic [LW-1:0]   bwd_arlen   [0:N-1];
  logic [1:0]      bwd_arburst [0:N-1];
  logic [IDW-1:0]  bwd_awid    [0:N-1];
  logic [31:0]     bwd_awaddr  [0:N-1];
  logic [LW-1:0]   bwd_awlen   [0:N-1];
  logic [1:0]      bwd_awburst [0:N-1];
  logic [N-1:0]    bwd_atx_vld;
  logic [N-1:0]    bwd_atx_rdy;
  logic [N*AW-1:0] chn_arb_rate;
  logic            arb_mode;
  logic            atx_done_vld;
  logic [CW-1:0]   atx_done_chn_id;
  logic [CW-1:0]   fwd_atx_chn_id;
  logic [IDW-1:0]  fwd_arid, fwd_awid;
  logic [31:0]     fwd_araddr, fwd_awaddr;
  logic [LW-1:0]   fwd_arlen, fwd_awlen;
  logic [1:0]      fwd_arburst, fwd_awburst;
  logic            fwd_atx_vld;
  logic            fwd_atx_rdy;
  logic [N*OW-1:0] chn_ost_cnt;

  adma_as_atx_sched #(
    .DMA_CHN_NUM (N), .DMA_CHN_ARB_W (AW), .SRC_ADDR_W (32), .DST_ADDR_W (32),
    .MST_ID_W (IDW), .ATX_LEN_W (LW), .OST_MAX (OMAX)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .bwd_arid (bwd_arid), .bwd_araddr (bwd_araddr), .bwd_arlen (bwd_arlen), .bwd_arburst (bwd_arburst),
    .bwd_awid (bwd_awid), .bwd_awaddr (bwd_awaddr), .bwd_awlen (bwd_awlen), .bwd_awburst (bwd_awburst),
    .bwd_atx_vld (bwd_atx_vld), .bwd_atx_rdy (bwd_atx_rdy),
    .chn_arb_rate (chn_arb_rate), .arb_mode (arb_mode),
    .atx_done_vld (atx_done_vld), .atx_done_chn_id (atx_done_chn_id),
    .fwd_atx_chn_id (fwd_atx_chn_id),
    .fwd_arid (fwd_arid), .fwd_araddr (fwd_araddr), .fwd_arlen (fwd_arlen), .fwd_arburst (fwd_arburst),
    .fwd_awid (fwd_awid), .fwd_awaddr (fwd_awaddr), .fwd_awlen (fwd_awlen), .fwd_awburst (fwd_awburst),
    .fwd_atx_vld (fwd_atx_vld), .fwd_atx_rdy (fwd_atx_rdy),
    .chn_ost_cnt (chn_ost_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [PW-1:0] sb_q [$];

  // Reference model: current owner, grants left in its turn, outstanding counts, output slot.
  int            m_cur, m_left, m_g;
  int            m_ost [N];
  bit            m_vld;
  logic [PW-1:0] m_out;
  int            dut_gnt, last_gnt;
  int            pat [$];

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] in_pack(input int c);
    return {CW'(c), bwd_arid[c], bwd_araddr[c], bwd_arlen[c], bwd_arburst[c],
            bwd_awid[c], bwd_awaddr[c], bwd_awlen[c], bwd_awburst[c]};
  endfunction

  function automatic logic [PW-1:0] dut_pack();
    return {fwd_atx_chn_id, fwd_arid, fwd_araddr, fwd_arlen, fwd_arburst,
            fwd_awid, fwd_awaddr, fwd_awlen, fwd_awburst};
  endfunction

  task automatic model_eval();
    bit elig [N];
    for (int i = 0; i < N; i++) elig[i] = bwd_atx_vld[i] && (m_ost[i] < OMAX);
    m_g = -1;
    if (!m_vld || fwd_atx_rdy) begin
      if (m_left > 0 && elig[m_cur]) m_g = m_cur;
      else for (int k = 1; k <= N; k++) if (m_g < 0 && elig[(m_cur + k) % N]) m_g = (m_cur + k) % N;
    end
  endtask

  task automatic model_step();
    int r, d;
    if (m_g >= 0) begin
      if (m_g == m_cur && m_left > 0) m_left--;
      else begin
        r      = int'(chn_arb_rate[m_g*AW +: AW]);
        m_cur  = m_g;
        m_left = ((arb_mode && r > 0) ? r : 1) - 1;
      end
      m_out = in_pack(m_g);
      m_vld = 1'b1;
      sb_q.push_back(m_out);
    end else if (fwd_atx_rdy) begin
      m_vld = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      d = (atx_done_vld && int'(atx_done_chn_id) == i && m_ost[i] > 0) ? 1 : 0;
      m_ost[i] = m_ost[i] + ((m_g == i) ? 1 : 0) - d;
    end
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic cycle();
    logic [N-1:0]    exp_rdy;
    logic [N*OW-1:0] exp_ost;
    #2;
    model_eval();
    exp_rdy = '0;
    if (m_g >= 0) exp_rdy[m_g] = 1'b1;
    for (int i = 0; i < N; i++) exp_ost[i*OW +: OW] = OW'(m_ost[i]);
    chk("bwd_atx_rdy", bwd_atx_rdy, exp_rdy);
    chk("fwd_atx_vld", fwd_atx_vld, m_vld);
    if (m_vld) chk("fwd_hold", dut_pack(), m_out);
    chk("chn_ost_cnt", chn_ost_cnt, exp_ost);
    dut_gnt = -1;
    for (int i = 0; i < N; i++) if (bwd_atx_rdy[i]) dut_gnt = i;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_fields();
    for (int i = 0; i < N; i++) begin
      bwd_arid[i]    = IDW'($urandom);
      bwd_araddr[i]  = $urandom;
      bwd_arlen[i]   = LW'($urandom);
      bwd_arburst[i] = 2'($urandom);
      bwd_awid[i]    = IDW'($urandom);
      bwd_awaddr[i]  = $urandom;
      bwd_awlen[i]   = LW'($urandom);
      bwd_awburst[i] = 2'($urandom);
    end
  endtask

  task automatic set_rates(input int r0, input int r1, input int r2, input int r3);
    chn_arb_rate = {AW'(r3), AW'(r2), AW'(r1), AW'(r0)};
  endtask

  task automatic do_reset(input bit check);
    bwd_atx_vld     = '0;
    fwd_atx_rdy     = 1'b0;
    atx_done_vld    = 1'b0;
    atx_done_chn_id = '0;
    #1 rst_n = 1'b0;
    #1;
    if (check) begin
      chk("rst_fwd_vld", fwd_atx_vld, 0);
      chk("rst_fwd_fields", dut_pack(), 0);
      chk("rst_ost", chn_ost_cnt, 0);
      chk("rst_bwd_rdy", bwd_atx_rdy, 0);
    end
    sb_q.delete();
    m_cur = 0; m_left = 0; m_vld = 1'b0; m_out = '0; last_gnt = -1;
    for (int i = 0; i < N; i++) m_ost[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // All channels valid, sink always ready, each grant completed on the following cycle.
  task automatic seq_check(input string name, input int off, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      set_fields();
      bwd_atx_vld     = '1;
      fwd_atx_rdy     = 1'b1;
      atx_done_vld    = (last_gnt >= 0);
      atx_done_chn_id = CW'((last_gnt < 0) ? 0 : last_gnt);
      cycle();
      chk(name, dut_gnt, pat[(c + off) % pat.size()]);
      last_gnt = dut_gnt;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && fwd_atx_vld && fwd_atx_rdy) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: output handshake with chn %0d, expected none", fwd_atx_chn_id);
        end else begin
          chk("fwd_txn", dut_pack(), sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, expected finish before time limit");
    $fatal(1);
  end

  int ost_gnt [7] = '{0, 0, 0, -1, -1, 0, -1};
  int ost_val [7] = '{1, 2, 3, 3, 2, 3, 3};

  initial begin
    rst_n = 1'b0;
    bwd_atx_vld = '0; fwd_atx_rdy = 1'b0; atx_done_vld = 1'b0; atx_done_chn_id = '0;
    arb_mode = 1'b0;
    set_rates(0, 0, 0, 0);
    set_fields();
    @(negedge clk);
    do_reset(1'b1);

    // After reset cur_chn=0 is scanned last, so the all-valid pattern starts at channel 1.
    arb_mode = 1'b1; set_rates(3, 1, 2, 1);
    do_reset(1'b0);
    pat = '{0, 0, 0, 1, 2, 2, 3};
    seq_check("wrr_seq", 3, 14);

    arb_mode = 1'b0;
    do_reset(1'b0);
    pat = '{0, 1, 2, 3};
    seq_check("rr_seq", 1, 8);

    arb_mode = 1'b1; set_rates(3, 1, 0, 1);
    do_reset(1'b0);
    pat = '{0, 0, 0, 1, 2, 3};
    seq_check("wrr_rate0_seq", 3, 12);

    // Outstanding cap on channel 0 and release by a single done.
    do_reset(1'b0);
    for (int c = 0; c < 7; c++) begin
      set_fields();
      bwd_atx_vld = 4'b0001; fwd_atx_rdy = 1'b1;
      atx_done_vld = (c == 4); atx_done_chn_id = '0;
      cycle();
      chk("ost_cap_gnt", dut_gnt, ost_gnt[c]);
      chk("ost_cap_cnt0", chn_ost_cnt[OW-1:0], ost_val[c]);
    end

    // Accept and done on channel 1 together, then done on an idle channel.
    do_reset(1'b0);
    set_fields(); bwd_atx_vld = 4'b0010; fwd_atx_rdy = 1'b1; cycle();
    set_fields(); atx_done_vld = 1'b1; atx_done_chn_id = 2'd1; cycle();
    chk("acc_done_same", chn_ost_cnt, 8'h04);
    bwd_atx_vld = '0; atx_done_chn_id = 2'd3; cycle();
    chk("done_at_zero", chn_ost_cnt, 8'h04);
    atx_done_vld = 1'b0;

    // Downstream stall with output valid, then release.
    arb_mode = 1'b1; set_rates(2, 2, 2, 2);
    do_reset(1'b0);
    for (int c = 0; c < 8; c++) begin
      set_fields();
      bwd_atx_vld     = '1;
      fwd_atx_rdy     = (c < 2 || c == 7);
      atx_done_vld    = (last_gnt >= 0);
      atx_done_chn_id = CW'((last_gnt < 0) ? 0 : last_gnt);
      cycle();
      if (c >= 2 && c < 7) chk("stall_no_rdy", dut_gnt, -1);
      if (c == 7) chk("stall_no_bubble", (dut_gnt >= 0), 1);
      last_gnt = dut_gnt;
    end

    // Build counts {ch3,ch2,ch1,ch0} = {3,0,1,2} with output valid, then reset mid-flight.
    arb_mode = 1'b0;
    do_reset(1'b0);
    for (int c = 0; c < 6; c++) begin
      set_fields();
      bwd_atx_vld = (c < 3) ? 4'b1000 : ((c < 5) ? 4'b0001 : 4'b0010);
      fwd_atx_rdy = 1'b1;
      cycle();
    end
    bwd_atx_vld = '0; fwd_atx_rdy = 1'b0; cycle();
    chk("pre_rst_ost", chn_ost_cnt, 8'hC6);
    chk("pre_rst_vld", fwd_atx_vld, 1);
    do_reset(1'b1);
    set_fields(); bwd_atx_vld = 4'b0001; fwd_atx_rdy = 1'b1; cycle();
    chk("rst_first_gnt", dut_gnt, 0);

    // Randomized traffic, weights and mode changing under the scheduler.
    do_reset(1'b0);
    for (int c = 0; c < 3000; c++) begin
      if (c % 37 == 0) chn_arb_rate = (N*AW)'($urandom);
      if (c % 101 == 0) arb_mode = 1'($urandom);
      set_fields();
      bwd_atx_vld     = N'($urandom) | N'($urandom);
      fwd_atx_rdy     = ($urandom_range(0, 3) != 0);
      atx_done_vld    = 1'($urandom);
      atx_done_chn_id = CW'($urandom);
      cycle();
    end

    bwd_atx_vld = '0; fwd_atx_rdy = 1'b1; atx_done_vld = 1'b0;
    repeat (3) cycle();
    chk("sb_drain", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
